dut_regbank: RTL and testbench

- Parametrised successor to the fixed three-register backdoor DUT.
- Holds NUM_REGS registers of DATA_W bits, each with its own reset value.
- Registers are reachable through a valid/ready request/response bus.
- One register index can be a free-running counter. Registers can be marked read-only.
- Storage is one flat, hierarchically addressable array so UVM register-model backdoor paths stay stable.

---
 rtl/dut_regbank_pkg.sv | 19 +
 rtl/dut_regbank_counter.sv | 35 +++
 rtl/dut_regbank.sv | 104 ++++++++++
 tb/tb_dut_regbank.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dut_regbank_pkg.sv
// dut_regbank_pkg: shared types and helpers for the register bank.
package dut_regbank_pkg;
  typedef enum logic {IDLE, RESP} state_t;
  localparam int MAX_REGS = 64;
  localparam int MAX_W = 256;
  // Any CNT_IDX >= NUM_REGS disables the counter; this value does so for every legal NUM_REGS.
  localparam int NO_COUNTER = MAX_REGS;
  function automatic logic [MAX_W-1:0] reset_val(input logic [MAX_REGS*MAX_W-1:0] vals,
                                                 input int i, input int w);
    return MAX_W'(vals >> (i * w));
  endfunction
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_v,
                                                  input logic [MAX_W-1:0] new_v,
                                                  input logic [MAX_W/8-1:0] strb);
    byte_merge = old_v;
    for (int b = 0; b < MAX_W / 8; b++)
      if (strb[b]) byte_merge[8*b +: 8] = new_v[8*b +: 8];
  endfunction
endpackage

// File: rtl/dut_regbank_counter.sv
// dut_regbank_counter: free-running counter register; a bus load wins over the increment.
module dut_regbank_counter
  import dut_regbank_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              r,
  input  logic              load,
  input  logic [DATA_W/8-1:0] load_mask,
  input  logic [DATA_W-1:0] load_data,
  input  logic              cnt_en,
  input  logic [DATA_W-1:0] rst_val,
  output logic [DATA_W-1:0] value,
  output logic              wrap
);
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic wrap_q, wrap_d;
  always_comb begin
    cnt_d = load ? DATA_W'(byte_merge(MAX_W'(cnt_q), MAX_W'(load_data), (MAX_W/8)'(load_mask)))
                 : cnt_en ? cnt_q + DATA_W'(1) : cnt_q;
    wrap_d = !load && cnt_en && (&cnt_q);
  end
  always_ff @(posedge clk) begin
    if (r) begin
      cnt_q  <= rst_val;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end
  assign value = cnt_q;
  assign wrap  = wrap_q;
endmodule

// File: rtl/dut_regbank.sv
// dut_regbank: parametrised register bank behind a valid/ready request/response bus.
// Define DUT_REGBANK_CHANGE_LOG_EN for simulation-only logging of every register change.
module dut_regbank
  import dut_regbank_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(NUM_REGS),
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = {32'h0, 32'h0, 32'hdeadbeef, 32'h12345678},
  parameter int CNT_IDX = 2,
  parameter logic [NUM_REGS-1:0] RO_MASK = 4'b1000
) (
  input  logic                clk,
  input  logic                r,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  input  logic                cnt_en,
  output logic                cnt_wrap
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic err_q, err_d;
  // Flat storage view; backdoor paths point here.
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic accept, in_range, ro, do_write;
  assign accept    = (state_q == IDLE) && req_valid;
  assign in_range  = 32'(req_addr) < NUM_REGS;
  assign ro        = in_range && RO_MASK[req_addr];
  assign do_write  = accept && req_write && in_range && !ro;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      state_d = RESP;
      rdata_d = (req_write || !in_range) ? '0 : regs[req_addr];
      err_d   = !in_range || (req_write && ro);
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [DATA_W-1:0] RST =
      DATA_W'(reset_val((MAX_REGS*MAX_W)'(RESET_VALS), i, DATA_W));
    logic wr;
    assign wr = do_write && (req_addr == ADDR_W'(i));
    if (i == CNT_IDX) begin : g_cnt
      dut_regbank_counter #(.DATA_W(DATA_W)) u_cnt (
        .clk       (clk),
        .r         (r),
        .load      (wr),
        .load_mask (req_wstrb),
        .load_data (req_wdata),
        .cnt_en    (cnt_en),
        .rst_val   (RST),
        .value     (regs[i]),
        .wrap      (cnt_wrap)
      );
    end else begin : g_plain
      logic [DATA_W-1:0] reg_q, reg_d;
      always_comb
        reg_d = wr ? DATA_W'(byte_merge(MAX_W'(reg_q), MAX_W'(req_wdata), (MAX_W/8)'(req_wstrb)))
                   : reg_q;
      always_ff @(posedge clk) reg_q <= r ? RST : reg_d;
      assign regs[i] = reg_q;
    end
  end
  if (CNT_IDX >= NUM_REGS || CNT_IDX < 0) begin : g_no_cnt
    logic unused_cnt_en;
    assign unused_cnt_en = cnt_en;
    assign cnt_wrap = 1'b0;
  end
`ifdef DUT_REGBANK_CHANGE_LOG_EN
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_log
    initial $display(" HW_INFO @ %0t: Instantiated %m.reg[%0d]", $time, i);
    always @(regs[i]) $display(" HW_INFO @ %0t: %m: reg[%0d] changed to %h", $time, i, regs[i]);
  end
`else
  // default build carries no logging
`endif
endmodule

// File: tb/tb_dut_regbank.sv
// tb_dut_regbank: randomized scoreboard bench with a behavioural model of the register bank.
module tb_dut_regbank;
  logic clk = 1'b0, r = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1, cnt_en = 1'b0;
  logic [1:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_wstrb = '0;
  logic req_ready, rsp_valid, rsp_err, cnt_wrap;
  logic [31:0] rsp_rdata;
  logic s_req_valid = 1'b0, s_req_write = 1'b0;
  logic [1:0] s_req_addr = '0;
  logic s_req_ready, s_rsp_valid, s_rsp_err, s_cnt_wrap;
  logic [31:0] s_rsp_rdata;

  always #5 clk = ~clk;

  dut_regbank dut (
    .clk(clk), .r(r), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cnt_en(cnt_en),
    .cnt_wrap(cnt_wrap)
  );

  dut_regbank #(
    .NUM_REGS(3), .RESET_VALS(96'h00000000_deadbeef_12345678), .CNT_IDX(3), .RO_MASK(3'b000)
  ) dut3 (
    .clk(clk), .r(r), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write),
    .req_addr(s_req_addr), .req_wdata(32'h00000001), .req_wstrb(4'hf), .rsp_valid(s_rsp_valid),
    .rsp_ready(1'b1), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err), .cnt_en(1'b1),
    .cnt_wrap(s_cnt_wrap)
  );

  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Behavioural model: register contents, one-outstanding bus, counter at index 2, reg 3 read-only.
  localparam logic [31:0] RV [4] = '{32'h12345678, 32'hdeadbeef, 32'h0, 32'h0};
  typedef struct packed {logic [31:0] d; logic e;} rsp_t;
  rsp_t exp_q[$];
  logic [31:0] mdl [4];
  bit busy = 0, exp_wrap = 0, started = 0, bump, bad;

  always @(posedge clk) begin
    if (r) begin
      for (int i = 0; i < 4; i++) mdl[i] = RV[i];
      busy = 0;
      exp_wrap = 0;
      exp_q.delete();
      started = 1;
    end else begin
      bump = cnt_en;
      exp_wrap = 0;
      if (!busy && req_valid) begin
        bad = req_write && (req_addr == 2'd3);
        exp_q.push_back('{req_write ? 32'h0 : mdl[req_addr], bad});
        if (req_write && !bad) begin
          for (int b = 0; b < 4; b++)
            if (req_wstrb[b]) mdl[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
          if (req_addr == 2'd2) bump = 0;
        end
        busy = 1;
      end else if (busy && rsp_ready) begin
        busy = 0;
      end
      if (bump) begin
        exp_wrap = mdl[2] == 32'hffffffff;
        mdl[2] = mdl[2] + 32'd1;
      end
    end
  end

  bit held = 0;
  logic [31:0] hd;
  logic he;
  rsp_t got;
  always @(negedge clk) begin
    if (started) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(busy));
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("cnt_wrap", 32'(cnt_wrap), 32'(exp_wrap));
      for (int i = 0; i < 4; i++) chk($sformatf("reg[%0d]", i), dut.regs[i], mdl[i]);
      if (rsp_valid && held) begin
        chk("hold_rdata", rsp_rdata, hd);
        chk("hold_err", 32'(rsp_err), 32'(he));
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, got.d);
          chk("rsp_err", 32'(rsp_err), 32'(got.e));
        end
      end
      held = rsp_valid && !rsp_ready;
      hd = rsp_rdata;
      he = rsp_err;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input bit w, input logic [1:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit rnd);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    cyc();
    req_valid = 1'b0;
    for (int k = 0; k < 64 && rsp_valid; k++) begin
      if (rnd) rsp_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    chk("xact_done", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;
  endtask

  task automatic s_xact(input bit w, input logic [1:0] a, input logic [31:0] ed, input logic ee);
    s_req_valid = 1'b1; s_req_write = w; s_req_addr = a;
    cyc();
    s_req_valid = 1'b0;
    chk("s_rsp_valid", 32'(s_rsp_valid), 32'd1);
    chk("s_rdata", s_rsp_rdata, ed);
    chk("s_err", 32'(s_rsp_err), 32'(ee));
    chk("s_cnt_wrap", 32'(s_cnt_wrap), 32'd0);
    cyc();
    chk("s_idle", 32'(s_rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    r = 1'b1;
    cyc(); cyc();
    r = 1'b0;
    s_xact(0, 2'd3, 32'h0, 1'b1);
    s_xact(1, 2'd3, 32'h0, 1'b1);
    s_xact(0, 2'd1, 32'hdeadbeef, 1'b0);
    s_xact(1, 2'd0, 32'h0, 1'b0);
    s_xact(0, 2'd0, 32'h00000001, 1'b0);
    for (int a = 0; a < 4; a++) xact(0, 2'(a), 32'h0, 4'h0, 0);
    xact(1, 2'd1, 32'haabbccdd, 4'b0101, 0);
    chk("byte_merge", dut.regs[1], 32'hdebbbedd);
    xact(0, 2'd1, 32'h0, 4'h0, 0);
    xact(1, 2'd2, 32'hffffffff, 4'hf, 0);
    cnt_en = 1'b1;
    cyc();
    chk("wrap_zero", dut.regs[2], 32'h0);
    chk("wrap_pulse", 32'(cnt_wrap), 32'd1);
    cyc();
    chk("wrap_one", dut.regs[2], 32'h1);
    chk("wrap_end", 32'(cnt_wrap), 32'd0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wdata = 32'h10; req_wstrb = 4'hf;
    cyc();
    req_valid = 1'b0;
    chk("collide_load", dut.regs[2], 32'h10);
    cyc();
    chk("collide_inc", dut.regs[2], 32'h11);
    cnt_en = 1'b0;
    xact(1, 2'd3, 32'h1, 4'hf, 0);
    chk("ro_keep", dut.regs[3], 32'h0);
    xact(1, 2'd0, 32'hffffffff, 4'h0, 0);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1;
    cyc();
    req_valid = 1'b0;
    repeat (5) cyc();
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd1; req_wdata = 32'h0; req_wstrb = 4'hf;
    cyc();
    req_valid = 1'b0;
    cyc();
    r = 1'b1;
    cyc();
    r = 1'b0;
    chk("rst_drop", 32'(rsp_valid), 32'd0);
    chk("rst_reg1", dut.regs[1], 32'hdeadbeef);
    rsp_ready = 1'b1;
    cyc();
    repeat (300) begin
      cnt_en = 1'($urandom_range(0, 1));
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 32'hfffffffe : $urandom, 4'($urandom_range(0, 15)), 1);
    end
    cnt_en = 1'b0;
    cyc();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
